// File: rtl/led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// led_matrix_scanner
//
// Time-multiplexes a 7x5 LED matrix, one column at a time. The three column
// patterns come from a left/right mirrored source:
//   col_2 -> columns 0 and 4
//   col_1 -> columns 1 and 3
//   col_0 -> column 2
// The patterns are frozen once per frame so the image cannot tear. Every
// column slot opens with BLANK cycles in which all pins are idle, which
// suppresses ghosting when the column changes.
//
// Ports
//   clock        system clock, rising edge
//   reset        asynchronous active-high reset
//   enable       scan enable; low = display off, scan parked at frame start
//   col_2/1/0    7-bit row patterns, bit i = row i lit
//   rows         row drive pins (polarity from ROW_ACTIVE_LOW)
//   cols         one-hot column select (polarity from COL_ACTIVE_LOW)
//   frame_start  one-cycle pulse on the first output cycle of column 0
// -----------------------------------------------------------------------------
module led_matrix_scanner #(
    parameter int DIVIDER        = 1000,
    parameter int BLANK          = 1,
    parameter int ROW_ACTIVE_LOW = 1,
    parameter int COL_ACTIVE_LOW = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] col_2,
    input  logic [6:0] col_1,
    input  logic [6:0] col_0,
    output logic [6:0] rows,
    output logic [4:0] cols,
    output logic       frame_start
);

    localparam int             PW        = $clog2(DIVIDER);
    localparam logic [PW-1:0]  PRE_LAST  = PW'(DIVIDER - 1);
    localparam logic [PW-1:0]  BLANK_END = PW'(BLANK);
    localparam logic [6:0]     ROWS_IDLE = (ROW_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [4:0]     COLS_IDLE = (COL_ACTIVE_LOW != 0) ? 5'h1F : 5'h00;

    logic [PW-1:0] pre_q, pre_d;
    logic [2:0]    idx_q, idx_d;
    logic [6:0]    l2_q, l2_d;
    logic [6:0]    l1_q, l1_d;
    logic [6:0]    l0_q, l0_d;
    logic [6:0]    rows_q, rows_d;
    logic [4:0]    cols_q, cols_d;
    logic          frame_start_q, frame_start_d;

    logic          frame_first;
    logic [6:0]    pattern;
    logic [4:0]    col_onehot;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pre_q         <= '0;
            idx_q         <= '0;
            l2_q          <= '0;
            l1_q          <= '0;
            l0_q          <= '0;
            rows_q        <= ROWS_IDLE;
            cols_q        <= COLS_IDLE;
            frame_start_q <= 1'b0;
        end else begin
            pre_q         <= pre_d;
            idx_q         <= idx_d;
            l2_q          <= l2_d;
            l1_q          <= l1_d;
            l0_q          <= l0_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            frame_start_q <= frame_start_d;
        end
    end

    always_comb begin
        pre_d         = pre_q;
        idx_d         = idx_q;
        l2_d          = l2_q;
        l1_d          = l1_q;
        l0_d          = l0_q;
        rows_d        = ROWS_IDLE;
        cols_d        = COLS_IDLE;
        frame_start_d = 1'b0;
        pattern       = l0_q;
        col_onehot    = 5'b00001 << idx_q;
        frame_first   = enable && (pre_q == '0) && (idx_q == 3'd0);

        if (!enable) begin
            // Park the scan at frame start; latches keep their last image.
            pre_d = '0;
            idx_d = 3'd0;
        end else begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                idx_d = (idx_q >= 3'd4) ? 3'd0 : idx_q + 3'd1;
            end else begin
                pre_d = pre_q + 1'b1;
            end

            if (frame_first) begin
                l2_d          = col_2;
                l1_d          = col_1;
                l0_d          = col_0;
                frame_start_d = 1'b1;
            end

            // In the frame-first cycle the latches are only being loaded,
            // so the live input is the correct source for column 0.
            case (idx_q)
                3'd0:    pattern = frame_first ? col_2 : l2_q;
                3'd4:    pattern = l2_q;
                3'd1,
                3'd3:    pattern = l1_q;
                default: pattern = l0_q;
            endcase

            if (pre_q >= BLANK_END) begin
                rows_d = (ROW_ACTIVE_LOW != 0) ? ~pattern : pattern;
                cols_d = (COL_ACTIVE_LOW != 0) ? ~col_onehot : col_onehot;
            end
        end
    end

    assign rows        = rows_q;
    assign cols        = cols_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scanner
//
// Directed bench for led_matrix_scanner with DIVIDER=4, BLANK=1. Instance a is
// active-low on both pin groups, instance b is active-high on both. Each table
// record holds the inputs for one clock cycle and the pins expected right after
// that cycle's rising edge. Hand-written sequences cover reset idle and the
// asynchronous reset taken between clock edges.
// -----------------------------------------------------------------------------
module tb_led_matrix_scanner;

    localparam logic [6:0] PAT_A  = 7'b1010001;
    localparam logic [6:0] PAT_B  = 7'b0001100;
    localparam logic [6:0] PAT_1  = 7'b0011100;
    localparam logic [6:0] PAT_0  = 7'b1111111;
    localparam logic [6:0] ROW_A  = 7'b0101110;
    localparam logic [6:0] ROW_B  = 7'b1110011;
    localparam logic [6:0] ROW_1  = 7'b1100011;
    localparam logic [6:0] ROW_0  = 7'b0000000;
    localparam logic [6:0] R_IDLE = 7'b1111111;
    localparam logic [4:0] C_IDLE = 5'b11111;

    typedef struct {
        logic       en;
        logic [6:0] c2;
        logic [6:0] c1;
        logic [6:0] c0;
        logic [6:0] rows;
        logic [4:0] cols;
        logic       fs;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b1;
    logic [6:0] col_2 = PAT_A;
    logic [6:0] col_1 = PAT_1;
    logic [6:0] col_0 = PAT_0;
    logic [6:0] rows_a, rows_b;
    logic [4:0] cols_a, cols_b;
    logic       fs_a, fs_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_on   = 1'b0;
    vec_t vecs[$];
    logic [4:0] prev_cols = 5'b11111;

    always #5 clock = ~clock;

    led_matrix_scanner #(
        .DIVIDER(4), .BLANK(1), .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(1)
    ) dut_a (
        .clock(clock), .reset(reset), .enable(enable),
        .col_2(col_2), .col_1(col_1), .col_0(col_0),
        .rows(rows_a), .cols(cols_a), .frame_start(fs_a)
    );

    led_matrix_scanner #(
        .DIVIDER(4), .BLANK(1), .ROW_ACTIVE_LOW(0), .COL_ACTIVE_LOW(0)
    ) dut_b (
        .clock(clock), .reset(reset), .enable(enable),
        .col_2(col_2), .col_1(col_1), .col_0(col_0),
        .rows(rows_b), .cols(cols_b), .frame_start(fs_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic en, input logic [6:0] c2, input logic [6:0] r,
                           input logic [4:0] c, input logic fs);
        vec_t v;
        v.en = en; v.c2 = c2; v.c1 = PAT_1; v.c0 = PAT_0;
        v.rows = r; v.cols = c; v.fs = fs;
        vecs.push_back(v);
    endtask

    // One column slot: a blanked cycle followed by three lit cycles.
    task automatic add_slot(input logic [6:0] c2, input logic [6:0] r,
                            input logic [4:0] c, input logic fs);
        add_vec(1'b1, c2, R_IDLE, C_IDLE, fs);
        for (int k = 0; k < 3; k++) add_vec(1'b1, c2, r, c, 1'b0);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Pin-level invariants on the active-low instance, every cycle.
    always @(negedge clock) begin
        if (mon_on) begin
            n_checks++;
            if ($countones(~cols_a) > 1) begin
                n_fail++;
                $display("FAIL onehot: cols=%b has more than one active bit", cols_a);
            end
            n_checks++;
            if (prev_cols != C_IDLE && cols_a != C_IDLE && cols_a != prev_cols) begin
                n_fail++;
                $display("FAIL blank_gap: cols %b -> %b without idle cycle", prev_cols, cols_a);
            end
            n_checks++;
            if (cols_a == C_IDLE && rows_a != R_IDLE) begin
                n_fail++;
                $display("FAIL rows_idle: rows=%b while no column selected, expected %b", rows_a, R_IDLE);
            end
            prev_cols = cols_a;
        end
    end

    initial begin
        // Frame 1: col_2 switches to B while column 2 is being shown.
        add_slot(PAT_A, ROW_A, 5'b11110, 1'b1);
        add_slot(PAT_A, ROW_1, 5'b11101, 1'b0);
        add_slot(PAT_B, ROW_0, 5'b11011, 1'b0);
        add_slot(PAT_B, ROW_1, 5'b10111, 1'b0);
        add_slot(PAT_B, ROW_A, 5'b01111, 1'b0);
        // Frame 2: B is picked up at the frame boundary.
        add_slot(PAT_B, ROW_B, 5'b11110, 1'b1);
        add_slot(PAT_B, ROW_1, 5'b11101, 1'b0);
        add_slot(PAT_B, ROW_0, 5'b11011, 1'b0);
        add_slot(PAT_B, ROW_1, 5'b10111, 1'b0);
        add_slot(PAT_B, ROW_B, 5'b01111, 1'b0);
        // Frame 3: enable drops at idx=3, pre=2.
        add_slot(PAT_B, ROW_B, 5'b11110, 1'b1);
        add_slot(PAT_B, ROW_1, 5'b11101, 1'b0);
        add_slot(PAT_B, ROW_0, 5'b11011, 1'b0);
        add_vec(1'b1, PAT_B, R_IDLE, C_IDLE, 1'b0);
        add_vec(1'b1, PAT_B, ROW_1, 5'b10111, 1'b0);
        for (int k = 0; k < 4; k++) add_vec(1'b0, PAT_B, R_IDLE, C_IDLE, 1'b0);
        // Re-enable with A on col_2: fresh frame, A latched.
        add_slot(PAT_A, ROW_A, 5'b11110, 1'b1);
        add_vec(1'b1, PAT_A, R_IDLE, C_IDLE, 1'b0);
        add_vec(1'b1, PAT_A, ROW_1, 5'b11101, 1'b0);

        // Reset held across edges: both polarities idle.
        repeat (2) step();
        check("reset_rows_a", 32'(rows_a), 32'(R_IDLE));
        check("reset_cols_a", 32'(cols_a), 32'(C_IDLE));
        check("reset_fs_a",   32'(fs_a),   32'd0);
        check("reset_rows_b", 32'(rows_b), 32'd0);
        check("reset_cols_b", 32'(cols_b), 32'd0);
        #2;
        reset  = 1'b0;
        mon_on = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            enable = vecs[i].en;
            col_2  = vecs[i].c2;
            col_1  = vecs[i].c1;
            col_0  = vecs[i].c0;
            step();
            $display("vec %0d: en=%b c2=%b -> rows=%b cols=%b fs=%b", i, vecs[i].en,
                     vecs[i].c2, rows_a, cols_a, fs_a);
            check($sformatf("vec%0d_rows", i), 32'(rows_a), 32'(vecs[i].rows));
            check($sformatf("vec%0d_cols", i), 32'(cols_a), 32'(vecs[i].cols));
            check($sformatf("vec%0d_fs",   i), 32'(fs_a),   32'(vecs[i].fs));
            if (i == 0) begin
                check("pol_fs_b",   32'(fs_b),   32'd1);
                check("pol_idle_b", 32'(cols_b), 32'd0);
            end
            if (i == 1) begin
                check("pol_cols_b", 32'(cols_b), 32'(5'b00001));
                check("pol_rows_b", 32'(rows_b), 32'(PAT_A));
            end
        end

        // Asynchronous reset between edges while column 1 is lit.
        check("pre_areset_lit", 32'(cols_a), 32'(5'b11101));
        #2;
        reset = 1'b1;
        #1;
        $display("areset: rows=%b cols=%b fs=%b", rows_a, cols_a, fs_a);
        check("areset_rows", 32'(rows_a), 32'(R_IDLE));
        check("areset_cols", 32'(cols_a), 32'(C_IDLE));
        check("areset_fs",   32'(fs_a),   32'd0);
        @(posedge clock);
        #3;
        enable = 1'b0;
        reset  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            $display("post_reset idle %0d: rows=%b cols=%b fs=%b", k, rows_a, cols_a, fs_a);
            check("post_reset_rows", 32'(rows_a), 32'(R_IDLE));
            check("post_reset_cols", 32'(cols_a), 32'(C_IDLE));
            check("post_reset_fs",   32'(fs_a),   32'd0);
        end
        enable = 1'b1;
        col_2  = PAT_B;
        step();
        $display("restart: rows=%b cols=%b fs=%b", rows_a, cols_a, fs_a);
        check("restart_fs",   32'(fs_a),   32'd1);
        check("restart_cols", 32'(cols_a), 32'(C_IDLE));
        step();
        $display("restart col0: rows=%b cols=%b fs=%b", rows_a, cols_a, fs_a);
        check("restart_col0_cols", 32'(cols_a), 32'(5'b11110));
        check("restart_col0_rows", 32'(rows_a), 32'(ROW_B));

        mon_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
